fifo_drain_arbiter: RTL

//  Round-robin read scheduler that drains N_CH byte-wide timetag FIFOs into one stream.
//  The FIFOs have registered outputs with 1-cycle read latency; this block owns their rd_en.

---
 rtl/fifo_drain_arbiter_pkg.sv | 20 ++
 rtl/fifo_drain_arbiter_drain_out_buf.sv | 54 +++++
 rtl/fifo_drain_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared definitions for the timetag FIFO drain arbiter: scheduler state encoding
// and a width helper used to size counters at elaboration time.
package fifo_drain_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_drain_out_buf.sv
// Two-entry in-order valid/ready output buffer holding {channel, word} pairs.
// Occupancy is exported so the scheduler can meter reads against free space.
module drain_out_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;
  assign w_pop   = o_valid && i_ready;

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  // The upstream credit rule must never let a push land on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && !w_pop && (r_occ == 2'd2)));
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin read scheduler: drains N_CH registered-output FIFOs in bursts of up
// to BURST words into one channel-tagged valid/ready stream, metered by buffer credit.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int BURST  = 4,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_CH-1:0]          fifo_empty,
  input  logic [N_CH*DATA_W-1:0]   fifo_dout,
  output logic [N_CH-1:0]          fifo_rd_en,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CNT_W = clog2(BURST + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [CH_W-1:0]     r_sel;
  logic [CH_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_rd_vld_p1;

  logic                w_grant_vld;
  logic [CH_W-1:0]     w_grant_ch;
  logic [CH_W:0]       w_rr_sum;
  logic [CH_W-1:0]     w_sel_inc;
  logic                w_sel_empty;
  logic                w_rd;
  logic                w_cnt_last;
  logic                w_credit_ok;
  logic                w_pop;
  logic [1:0]          w_occ;
  logic [DATA_W-1:0]   w_cap_data;
  logic [CH_W+DATA_W-1:0] w_buf_data;

  // Round-robin search: scan channels starting at rr_ptr, wrapping at N_CH.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_rr_sum    = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (w_rr_sum >= (CH_W+1)'(N_CH)) w_rr_sum = w_rr_sum - (CH_W+1)'(N_CH);
      if (!w_grant_vld && !fifo_empty[w_rr_sum[CH_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = w_rr_sum[CH_W-1:0];
      end
    end
  end

  assign w_sel_inc   = (r_sel == CH_W'(N_CH - 1)) ? '0 : r_sel + CH_W'(1);
  assign w_sel_empty = fifo_empty[r_sel];
  assign w_cnt_last  = (r_burst_cnt == CNT_W'(BURST - 1));
  assign w_pop       = out_valid && out_ready;
  // Words in the buffer plus the read in flight, less this cycle's pop, must leave room.
  assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_rd_vld_p1}) < (3'd2 + {2'b00, w_pop});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_grant_vld) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if ((w_rd && w_cnt_last) || (w_sel_empty && !w_rd)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_rd_vld_p1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd       = 1'b0;
    fifo_rd_en = '0;
    busy       = (r_state != ST_IDLE) || (w_occ != 2'd0);
    if (!rst && (r_state == ST_READ) && !w_sel_empty && w_credit_ok) begin
      w_rd = 1'b1;
    end
    fifo_rd_en[r_sel] = w_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_READ)) begin
        r_sel       <= w_grant_ch;
        r_burst_cnt <= '0;
      end else if (w_rd) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE)) begin
        r_rr_ptr <= w_sel_inc;
      end
    end
  end

  // p1 stage: the FIFO's registered output now holds the word read last cycle.
  always_comb begin
    w_cap_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_sel == CH_W'(i)) w_cap_data = fifo_dout[i*DATA_W +: DATA_W];
    end
  end

  drain_out_buf #(
    .W (CH_W + DATA_W)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_rd_vld_p1),
    .i_push_data ({r_sel, w_cap_data}),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_data      (w_buf_data),
    .o_occ       (w_occ)
  );

  assign {out_ch, out_data} = w_buf_data;

endmodule
